sobel_window_gen: RTL and testbench
===================================

Name: sobel_window_gen

Overview:
Line-buffer/window generator feeding the Sobel 2D skid buffer stage. Accepts a raster pixel stream, one 8-bit pixel per beat, over AXI-Stream. Holds the two previous image lines in on-chip RAM and emits one packed 3x3 neighbourhood per valid centre pixel on a strobe/busy handshake. Only interior windows are produced: (H-2) x (W-2) windows per frame, with out_tlast on the last window of the frame.

Parameters:
DATAWIDTH, 8, bits per pixel
PIXEL, 3, window columns
ROW_LOOP, 3, window rows
IMG_WIDTH, 640, pixels per line; minimum 3
COL_W, $clog2(IMG_WIDTH), column counter / RAM address width

Ports:
clk  in  1  clock
ARESETN  in  1  synchronous, active-low reset
s_axis_tdata  in  DATAWIDTH  input pixel, raster order
s_axis_tvalid  in  1  input pixel valid
s_axis_tready  out  1  input accept
s_axis_tlast  in  1  last pixel of frame
packed_out  out  DATAWIDTH*PIXEL*ROW_LOOP  window; element (i=column 0..2 left->right, j=row 0..2 top->bottom) at bit offset DATAWIDTH*(ROW_LOOP*i+j)
o_strobe  out  1  packed_out valid
i_busy  in  1  downstream busy; window consumed on o_strobe && !i_busy
out_tlast  out  1  frame-last flag, qualified by o_strobe

Behaviour:
- Reset, ARESETN low at posedge clk: o_strobe=0, out_tlast=0, packed_out=0, col=0, row=0, pipeline valids=0. s_axis_tready is 1 the cycle after reset. RAM contents are not cleared.
- stall = o_strobe && i_busy.
- s_axis_tready = !stall (combinational).
- accept = s_axis_tvalid && s_axis_tready.
- Stage 1 (accept cycle):
  - line RAM, IMG_WIDTH x 2*DATAWIDTH, single port, read-before-write at address col.
  - Reads {line[y-2][col], line[y-1][col]}, writes {line[y-1][col], pixel}.
  - Registers pixel, tlast, col, row and the window-valid flag v1.
  - v1 = (row>=2) && (col>=2).
- Stage 2:
  - Shift window one column left. New column i=2 = {j0: RAM y-2, j1: RAM y-1, j2: pixel}.
  - Shift happens for every accepted pixel, including non-emitting ones, so columns 0/1 are primed at line start.
  - o_strobe <= v1. out_tlast <= tlast && v1.
- Latency: a pixel accepted in cycle N produces o_strobe in cycle N+2 with no stall.
- Throughput: 1 window/cycle.
- Stall: both stages and the RAM read enable freeze while stall=1. packed_out and out_tlast are held stable. No window is dropped or duplicated.
- Consume with no new data: o_strobe drops to 0 when stage 1 holds no valid window.
- Counters:
  - col increments per accept; wraps IMG_WIDTH-1 -> 0 and increments row.
  - row saturates at 2.
- Frame end: an accept with s_axis_tlast forces col=0 and row=0 for the next pixel. Stale RAM lines are masked because row restarts at 0.
- Malformed frame (tlast with col != IMG_WIDTH-1): counters still reset. out_tlast is emitted only if that pixel produced a window; otherwise no out_tlast is issued for the frame.
- Simultaneous i_busy falling and new accept: the held window is consumed and the next window loads in the same edge.
- Reset mid-frame: all in-flight windows are discarded; the next pixel is treated as frame row 0, col 0.
- No arithmetic on pixel data; pure data movement.

Decomposition:
- Shared package sobel_pkg:
  - DATAWIDTH, PIXEL, ROW_LOOP, IMG_WIDTH defaults
  - typedef pixel_t = logic [DATAWIDTH-1:0]
  - typedef window_t = pixel_t [PIXEL][ROW_LOOP]
  - pack/unpack helper functions matching the bit-offset rule above
- One sub-module, sobel_line_ram:
  - single-port read-before-write synchronous RAM with read enable
  - width 2*DATAWIDTH, depth IMG_WIDTH
  - infers BRAM

Test Plan:
1. IMG_WIDTH=4, 4x4 frame, pixel value = 4*y+x, i_busy=0, tvalid constant -> exactly 4 windows. First window columns {0,4,8},{1,5,9},{2,6,10}, centre 5. Last window has centre 10 with out_tlast=1. First o_strobe occurs 2 cycles after accepting pixel 10.
2. Same frame, i_busy=1 for 5 cycles starting at the first o_strobe -> s_axis_tready=0 during the stall. packed_out is held at the centre-5 window. All 4 windows arrive in order after release.
3. Two back-to-back 4x4 frames (second frame = first + 100) -> 8 windows. The second frame's first window centre is 105 with no stale data from frame 1. out_tlast is asserted twice.
4. Random tvalid gaps (~50%) and random i_busy on a 640x8 frame -> scoreboard matches a golden 3x3 extraction. Window count is 638*6=3828; exactly one out_tlast.
5. Assert ARESETN for 1 cycle mid-row 3 -> o_strobe=0, out_tlast=0, packed_out=0 next cycle. A following clean 4x4 frame produces exactly the 4 correct windows.
6. Malformed frame: tlast on pixel (row 1, col 2) -> no windows and no out_tlast. The next clean frame is correct.

Source files
------------

// File: rtl/sobel_pkg.sv
// Shared types and defaults for the Sobel window front end.
// A window is PIXEL columns by ROW_LOOP rows of pixels; element (i, j) sits at DATAWIDTH*(ROW_LOOP*i+j).
package sobel_pkg;

  localparam int unsigned DATAWIDTH = 8;
  localparam int unsigned PIXEL     = 3;
  localparam int unsigned ROW_LOOP  = 3;
  localparam int unsigned IMG_WIDTH = 640;
  localparam int unsigned WIN_W     = DATAWIDTH * PIXEL * ROW_LOOP;

  typedef logic [DATAWIDTH-1:0] pixel_t;
  typedef pixel_t [PIXEL-1:0][ROW_LOOP-1:0] window_t;

  // Flatten a window into the bus layout (column-major, top row lowest).
  function automatic logic [WIN_W-1:0] pack_window(input window_t w);
    logic [WIN_W-1:0] p;
    p = '0;
    for (int i = 0; i < int'(PIXEL); i++) begin
      for (int j = 0; j < int'(ROW_LOOP); j++) begin
        p[DATAWIDTH*(ROW_LOOP*i+j) +: DATAWIDTH] = w[i][j];
      end
    end
    return p;
  endfunction

  function automatic window_t unpack_window(input logic [WIN_W-1:0] p);
    window_t w;
    for (int i = 0; i < int'(PIXEL); i++) begin
      for (int j = 0; j < int'(ROW_LOOP); j++) begin
        w[i][j] = p[DATAWIDTH*(ROW_LOOP*i+j) +: DATAWIDTH];
      end
    end
    return w;
  endfunction

endpackage

// File: rtl/sobel_line_ram.sv
// Single-port synchronous line RAM, read-before-write, with read enable and per-half write enables.
// Each word holds two line slots; the caller picks which slot receives the new pixel.
module sobel_line_ram #(
  parameter int unsigned DW    = 8,
  parameter int unsigned DEPTH = 640,
  parameter int unsigned AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          en,
  input  logic [1:0]    we,
  input  logic [AW-1:0] addr,
  input  logic [2*DW-1:0] wdata,
  output logic [2*DW-1:0] rdata
);

  logic [2*DW-1:0] mem [DEPTH];

  // Old contents are returned on the same edge that overwrites them.
  always_ff @(posedge clk) begin
    if (en) begin
      rdata <= mem[addr];
      if (we[0]) mem[addr][DW-1:0]    <= wdata[DW-1:0];
      if (we[1]) mem[addr][2*DW-1:DW] <= wdata[2*DW-1:DW];
    end
  end

endmodule

// File: rtl/sobel_window_gen.sv
// Line-buffer / 3x3 window generator: raster AXI-Stream pixels in, one interior window per
// valid centre pixel out on a strobe/busy handshake, with a frame-last flag.
module sobel_window_gen #(
  parameter int unsigned DATAWIDTH = sobel_pkg::DATAWIDTH,
  parameter int unsigned PIXEL     = sobel_pkg::PIXEL,
  parameter int unsigned ROW_LOOP  = sobel_pkg::ROW_LOOP,
  parameter int unsigned IMG_WIDTH = sobel_pkg::IMG_WIDTH,
  parameter int unsigned COL_W     = $clog2(IMG_WIDTH)
) (
  input  logic                                clk,
  input  logic                                ARESETN,
  input  logic [DATAWIDTH-1:0]                s_axis_tdata,
  input  logic                                s_axis_tvalid,
  output logic                                s_axis_tready,
  input  logic                                s_axis_tlast,
  output logic [DATAWIDTH*PIXEL*ROW_LOOP-1:0] packed_out,
  output logic                                o_strobe,
  input  logic                                i_busy,
  output logic                                out_tlast
);
  import sobel_pkg::*;

  localparam int unsigned ROW_W = 2;
  localparam logic [COL_W-1:0] LAST_COL = COL_W'(IMG_WIDTH - 1);
  localparam logic [COL_W-1:0] MIN_COL  = COL_W'(2);
  localparam logic [ROW_W-1:0] MAX_ROW  = ROW_W'(2);

  logic stall_c;
  logic accept_c;

  // Raster position of the pixel currently on the input, plus which RAM slot holds line y-2.
  logic [COL_W-1:0] col, col_nxt;
  logic [ROW_W-1:0] row, row_nxt;
  logic             par, par_nxt;

  // Stage 1: accepted pixel and its metadata, aligned with the RAM read data.
  logic                 s1_valid;
  logic                 s1_v;
  logic                 s1_last;
  logic                 s1_par;
  logic [DATAWIDTH-1:0] s1_pix;

  logic [2*DATAWIDTH-1:0] ram_rdata;
  logic [2*DATAWIDTH-1:0] ram_wdata;
  logic [1:0]             ram_we;
  logic [DATAWIDTH-1:0]   top_c;
  logic [DATAWIDTH-1:0]   mid_c;

  // Stage 2: the window itself, column 0 is the leftmost.
  logic [PIXEL-1:0][ROW_LOOP-1:0][DATAWIDTH-1:0] win;

  assign stall_c       = o_strobe & i_busy;
  assign s_axis_tready = ~stall_c;
  assign accept_c      = s_axis_tvalid & ~stall_c;
  assign packed_out    = win;

  // New pixel always replaces the older of the two stored lines.
  assign ram_wdata = {s_axis_tdata, s_axis_tdata};
  assign ram_we    = {accept_c & par, accept_c & ~par};

  sobel_line_ram #(
    .DW    (DATAWIDTH),
    .DEPTH (IMG_WIDTH),
    .AW    (COL_W)
  ) u_line_ram (
    .clk   (clk),
    .en    (accept_c),
    .we    (ram_we),
    .addr  (col),
    .wdata (ram_wdata),
    .rdata (ram_rdata)
  );

  assign top_c = s1_par ? ram_rdata[2*DATAWIDTH-1:DATAWIDTH] : ram_rdata[DATAWIDTH-1:0];
  assign mid_c = s1_par ? ram_rdata[DATAWIDTH-1:0] : ram_rdata[2*DATAWIDTH-1:DATAWIDTH];

  // Raster counters; tlast restarts the frame regardless of where it lands.
  always_comb begin
    col_nxt = col;
    row_nxt = row;
    par_nxt = par;
    if (accept_c) begin
      if (s_axis_tlast) begin
        col_nxt = '0;
        row_nxt = '0;
        par_nxt = ~par;
      end else if (col == LAST_COL) begin
        col_nxt = '0;
        par_nxt = ~par;
        if (row != MAX_ROW) row_nxt = row + ROW_W'(1);
      end else begin
        col_nxt = col + COL_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!ARESETN) begin
      col <= '0;
      row <= '0;
      par <= 1'b0;
    end else begin
      col <= col_nxt;
      row <= row_nxt;
      par <= par_nxt;
    end
  end

  // Two-stage pipeline; everything freezes while the presented window is held.
  always_ff @(posedge clk) begin
    if (!ARESETN) begin
      s1_valid  <= 1'b0;
      s1_v      <= 1'b0;
      s1_last   <= 1'b0;
      s1_par    <= 1'b0;
      s1_pix    <= '0;
      win       <= '0;
      o_strobe  <= 1'b0;
      out_tlast <= 1'b0;
    end else if (!stall_c) begin
      s1_valid <= accept_c;
      if (accept_c) begin
        s1_pix  <= s_axis_tdata;
        s1_last <= s_axis_tlast;
        s1_par  <= par;
        s1_v    <= (row == MAX_ROW) && (col >= MIN_COL);
      end
      if (s1_valid) begin
        for (int i = 0; i < int'(PIXEL) - 1; i++) begin
          win[i] <= win[i+1];
        end
        win[PIXEL-1][0] <= top_c;
        win[PIXEL-1][1] <= mid_c;
        win[PIXEL-1][2] <= s1_pix;
        o_strobe        <= s1_v;
        out_tlast       <= s1_last & s1_v;
      end else begin
        o_strobe  <= 1'b0;
        out_tlast <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_sobel_window_gen.sv
// Scoreboard bench for sobel_window_gen: a 4-wide instance for directed frames and a
// 640-wide instance for a long randomized frame, both checked against a frame-image model.
module tb_sobel_window_gen;

  typedef struct packed {
    logic [71:0] win;
    logic        last;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rstn;
  logic [7:0]  d4, d6;
  logic        v4, l4, r4, st4, b4, t4;
  logic        v6, l6, r6, st6, b6, t6;
  logic [71:0] p4, p6;

  sobel_window_gen #(.IMG_WIDTH(4)) dut4 (
    .clk(clk), .ARESETN(rstn), .s_axis_tdata(d4), .s_axis_tvalid(v4), .s_axis_tready(r4),
    .s_axis_tlast(l4), .packed_out(p4), .o_strobe(st4), .i_busy(b4), .out_tlast(t4));

  sobel_window_gen #(.IMG_WIDTH(640)) dut6 (
    .clk(clk), .ARESETN(rstn), .s_axis_tdata(d6), .s_axis_tvalid(v6), .s_axis_tready(r6),
    .s_axis_tlast(l6), .packed_out(p6), .o_strobe(st6), .i_busy(b6), .out_tlast(t6));

  exp_t        q4[$], q6[$];
  logic [7:0]  c4[$];
  logic [7:0]  fb [2][0:5119];
  int          fbn [2];
  int          win_cnt [2];
  int          tl_cnt [2];
  int          first_cyc [2];
  int          acc_cyc [2];
  int          n_cmp, n_err;
  int          cyc;
  int          stall_seen;
  bit          arm4, rnd6;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic void check(input string name, input logic [71:0] got, input logic [71:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, got, exp);
    end
  endfunction

  // Reference: place each pixel in its frame image; every interior pixel yields the window ending at it.
  function automatic void model_push(input int d, input logic [7:0] pix, input logic last, input int w);
    int k, y, x;
    exp_t e;
    k = fbn[d];
    fb[d][k] = pix;
    fbn[d] = k + 1;
    y = k / w;
    x = k % w;
    if (y >= 2 && x >= 2) begin
      e.win = '0;
      for (int i = 0; i < 3; i++)
        for (int j = 0; j < 3; j++)
          e.win[8*(3*i+j) +: 8] = fb[d][(y-2+j)*w + (x-2+i)];
      e.last = last;
      if (d == 0) q4.push_back(e); else q6.push_back(e);
    end
    if (last) fbn[d] = 0;
  endfunction

  function automatic void pop(input int d, input logic [71:0] got, input logic gl);
    exp_t e;
    if ((d == 0 && q4.size() == 0) || (d == 1 && q6.size() == 0)) begin
      n_cmp++;
      n_err++;
      $display("FAIL unexpected window dut%0d: got %h, expected none", d, got);
      return;
    end
    e = (d == 0) ? q4.pop_front() : q6.pop_front();
    check($sformatf("window dut%0d #%0d", d, win_cnt[d]), got, e.win);
    check($sformatf("out_tlast dut%0d #%0d", d, win_cnt[d]), 72'(gl), 72'(e.last));
    win_cnt[d]++;
    if (gl) tl_cnt[d]++;
    if (d == 0) c4.push_back(got[39:32]);
  endfunction

  // Monitors: a window is consumed at the edge following a sample of strobe && !busy.
  always @(negedge clk) begin
    if (rstn && st4 && first_cyc[0] < 0) first_cyc[0] = cyc;
    if (rstn && st4 && !b4) pop(0, p4, t4);
  end

  always @(negedge clk) begin
    if (rstn && st6 && !b6) pop(1, p6, t6);
  end

  // Directed stall on dut4: hold busy for 5 cycles from the first strobe once armed.
  initial begin
    logic [71:0] held;
    b4 = 1'b0;
    forever begin
      @(posedge clk); #1;
      if (arm4 && st4) begin
        arm4 = 1'b0;
        held = p4;
        b4 = 1'b1;
        stall_seen++;
        check("stall centre", 72'(held[39:32]), 72'(5));
        repeat (5) begin
          @(negedge clk);
          check("stall tready", 72'(r4), 72'(0));
          check("stall strobe", 72'(st4), 72'(1));
          check("stall hold", p4, held);
          @(posedge clk); #1;
        end
        b4 = 1'b0;
      end
    end
  end

  // Random backpressure on dut6.
  initial begin
    b6 = 1'b0;
    forever begin
      @(posedge clk); #1;
      b6 = rnd6 ? ($urandom_range(0, 1) == 1) : 1'b0;
    end
  end

  initial begin
    #1500000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  task automatic send(input int d, input logic [7:0] pix, input logic last, input int gap);
    int n;
    repeat (gap) begin @(posedge clk); #1; end
    if (d == 0) begin d4 = pix; l4 = last; v4 = 1'b1; end
    else        begin d6 = pix; l6 = last; v6 = 1'b1; end
    n = 0;
    forever begin
      @(negedge clk);
      if ((d == 0 && r4) || (d == 1 && r6)) break;
      n++;
      if (n > 2000) begin
        n_cmp++;
        n_err++;
        $display("FAIL tready timeout dut%0d: got 0, expected 1", d);
        break;
      end
    end
    if (n <= 2000) begin
      model_push(d, pix, last, (d == 0) ? 4 : 640);
      acc_cyc[d] = cyc;
    end
    @(posedge clk); #1;
    if (d == 0) v4 = 1'b0; else v6 = 1'b0;
  endtask

  task automatic drain(input int d);
    int n;
    n = 0;
    while (((d == 0) ? q4.size() : q6.size()) != 0 && n < 500) begin
      @(posedge clk); #1;
      n++;
    end
    repeat (6) begin @(posedge clk); #1; end
    check($sformatf("drain dut%0d", d), 72'((d == 0) ? q4.size() : q6.size()), 72'(0));
  endtask

  task automatic clear_stats(input int d);
    win_cnt[d] = 0;
    tl_cnt[d] = 0;
    first_cyc[d] = -1;
    if (d == 0) c4.delete();
  endtask

  function automatic logic [7:0] c4_at(input int i);
    return (i < c4.size()) ? c4[i] : 8'hff;
  endfunction

  task automatic frame4(input int base);
    for (int k = 0; k < 16; k++) send(0, 8'(base + k), k == 15, 0);
  endtask

  initial begin
    int a10;
    rstn = 1'b0;
    d4 = '0; v4 = 1'b0; l4 = 1'b0;
    d6 = '0; v6 = 1'b0; l6 = 1'b0;
    arm4 = 1'b0; rnd6 = 1'b0;
    clear_stats(0);
    clear_stats(1);
    repeat (3) @(posedge clk);
    #1;
    check("reset strobe", 72'(st4), 72'(0));
    check("reset tlast", 72'(t4), 72'(0));
    check("reset packed", p4, 72'(0));
    check("reset strobe w640", 72'(st6), 72'(0));
    check("reset packed w640", p6, 72'(0));
    rstn = 1'b1;
    @(posedge clk); #1;
    check("tready after reset", 72'(r4), 72'(1));
    check("tready after reset w640", 72'(r6), 72'(1));

    // Basic 4x4 frame
    clear_stats(0);
    a10 = 0;
    for (int k = 0; k < 16; k++) begin
      send(0, 8'(k), k == 15, 0);
      if (k == 10) a10 = acc_cyc[0];
    end
    drain(0);
    check("t1 windows", 72'(win_cnt[0]), 72'(4));
    check("t1 tlasts", 72'(tl_cnt[0]), 72'(1));
    check("t1 first centre", 72'(c4_at(0)), 72'(5));
    check("t1 last centre", 72'(c4_at(3)), 72'(10));
    check("t1 latency", 72'(first_cyc[0] - a10), 72'(2));

    // Same frame with a 5-cycle stall on the first window
    clear_stats(0);
    stall_seen = 0;
    arm4 = 1'b1;
    frame4(0);
    drain(0);
    check("t2 stall occurred", 72'(stall_seen), 72'(1));
    check("t2 windows", 72'(win_cnt[0]), 72'(4));
    check("t2 first centre", 72'(c4_at(0)), 72'(5));

    // Two back-to-back frames
    clear_stats(0);
    frame4(0);
    frame4(100);
    drain(0);
    check("t3 windows", 72'(win_cnt[0]), 72'(8));
    check("t3 tlasts", 72'(tl_cnt[0]), 72'(2));
    check("t3 frame2 centre", 72'(c4_at(4)), 72'(105));

    // Reset in the middle of row 3 with a window in flight
    for (int k = 0; k < 15; k++) send(0, 8'(k + 50), 1'b0, 0);
    rstn = 1'b0;
    @(posedge clk); #1;
    q4.delete();
    fbn[0] = 0;
    check("t5 reset strobe", 72'(st4), 72'(0));
    check("t5 reset tlast", 72'(t4), 72'(0));
    check("t5 reset packed", p4, 72'(0));
    rstn = 1'b1;
    clear_stats(0);
    frame4(20);
    drain(0);
    check("t5 windows", 72'(win_cnt[0]), 72'(4));
    check("t5 first centre", 72'(c4_at(0)), 72'(25));

    // Malformed frame ending at row 1 col 2, then a clean frame
    clear_stats(0);
    for (int k = 0; k < 7; k++) send(0, 8'(k + 200), k == 6, 0);
    drain(0);
    check("t6 malformed windows", 72'(win_cnt[0]), 72'(0));
    frame4(60);
    drain(0);
    check("t6 windows", 72'(win_cnt[0]), 72'(4));
    check("t6 tlasts", 72'(tl_cnt[0]), 72'(1));

    // Long randomized 640x8 frame with input gaps and backpressure
    clear_stats(1);
    rnd6 = 1'b1;
    for (int k = 0; k < 640 * 8; k++)
      send(1, 8'($urandom), k == 640 * 8 - 1, $urandom_range(0, 1));
    drain(1);
    rnd6 = 1'b0;
    check("t4 windows", 72'(win_cnt[1]), 72'(3828));
    check("t4 tlasts", 72'(tl_cnt[1]), 72'(1));

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end

endmodule
